asm_dp: RTL and testbench



---
 rtl/asm_dp_pkg.sv | 48 ++++
 rtl/asm_dp_onehot_enc.sv | 27 ++
 rtl/asm_dp.sv | 116 +++++++++++
 tb/tb_asm_dp.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/asm_dp_pkg.sv
// Shared types for the ASM datapath: state index, micro-op codes, default
// widths and the state-to-micro-op mapping.
package asm_dp_pkg;

    localparam int A_W_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    // Controller state index; index 0 corresponds to dec_in bit 7.
    typedef enum logic [2:0] {
        S000 = 3'd0,
        S001 = 3'd1,
        S010 = 3'd2,
        S011 = 3'd3,
        S100 = 3'd4,
        S101 = 3'd5,
        S110 = 3'd6,
        S111 = 3'd7
    } state_e;

    // Register-transfer micro-operation applied to the accumulator.
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_INC  = 3'd1,
        OP_HOLD = 3'd2,
        OP_CLR  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHL  = 3'd5,
        OP_CPL  = 3'd6
    } op_e;

    // S010 and S100 are test states for the controller, so the datapath holds.
    function automatic op_e state_to_op(input state_e s);
        op_e op;
        case (s)
            S000:    op = OP_LOAD;
            S001:    op = OP_INC;
            S010:    op = OP_HOLD;
            S011:    op = OP_CLR;
            S100:    op = OP_HOLD;
            S101:    op = OP_DEC;
            S110:    op = OP_SHL;
            S111:    op = OP_CPL;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/asm_dp_onehot_enc.sv
// One-hot to index encoder: inverse of the controller's state decoder.
// dec_in bit 7 maps to index 0, bit 0 to index 7; valid only when exactly
// one bit is set.
module onehot_enc (
    input  logic [7:0] dec_in,
    output logic [2:0] idx,
    output logic       valid
);

    logic [3:0] hit_cnt_s;

    // Encode the set bit position and count set bits to qualify the result.
    always_comb begin
        idx       = 3'd0;
        hit_cnt_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (dec_in[i]) begin
                idx       = 3'(7 - i);
                hit_cnt_s = hit_cnt_s + 4'd1;
            end else begin
                hit_cnt_s = hit_cnt_s;
            end
        end
        valid = (hit_cnt_s == 4'd1);
    end

endmodule

// File: rtl/asm_dp.sv
// ASM datapath: executes one accumulator micro-op per cycle from the
// controller's one-hot state decode and returns status flags E and F.
// Optional feature macro: ASM_DP_ONEHOT_CHECK_EN (sticky illegal-decode flag).
module asm_dp
    import asm_dp_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       dec_in,
    input  logic [A_W-1:0]   data_in,
    output logic [A_W-1:0]   A,
    output logic             E,
    output logic             F,
    output logic             done,
    output logic [CNT_W-1:0] busy_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       idx_s;
    logic             valid_s;
    op_e              op_s;
    logic [A_W-1:0]   a_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [A_W-1:0]   a_r;
    logic [CNT_W-1:0] busy_cnt_r;
    logic             done_r;

    onehot_enc u_enc (
        .dec_in (dec_in),
        .idx    (idx_s),
        .valid  (valid_s)
    );

    // Map the decoded state index onto its micro-op.
    always_comb begin
        op_s = state_to_op(state_e'(idx_s));
    end

    // Next accumulator value; illegal decodes hold the accumulator.
    always_comb begin
        a_next_s = a_r;
        if (valid_s) begin
            case (op_s)
                OP_LOAD: a_next_s = data_in;
                OP_INC:  a_next_s = a_r + A_W'(1);
                OP_HOLD: a_next_s = a_r;
                OP_CLR:  a_next_s = '0;
                OP_DEC:  a_next_s = a_r - A_W'(1);
                OP_SHL:  a_next_s = {a_r[A_W-2:0], 1'b0};
                OP_CPL:  a_next_s = ~a_r;
                default: a_next_s = a_r;
            endcase
        end else begin
            a_next_s = a_r;
        end
    end

    // Next busy count: cleared in S000, saturating increment in other valid states.
    always_comb begin
        cnt_next_s = busy_cnt_r;
        if (!valid_s) begin
            cnt_next_s = busy_cnt_r;
        end else if (op_s == OP_LOAD) begin
            cnt_next_s = '0;
        end else if (busy_cnt_r != CNT_MAX) begin
            cnt_next_s = busy_cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = busy_cnt_r;
        end
    end

    // Datapath registers: accumulator, busy counter and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            busy_cnt_r <= '0;
            done_r     <= 1'b0;
        end else begin
            a_r        <= a_next_s;
            busy_cnt_r <= cnt_next_s;
            done_r     <= valid_s && (op_s == OP_CLR);
        end
    end

`ifdef ASM_DP_ONEHOT_CHECK_EN
    logic err_r;

    // Sticky flag: any illegal decode sets it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (!valid_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Flags come straight from the accumulator register, never from inputs.
    assign A        = a_r;
    assign F        = a_r[A_W-1];
    assign E        = a_r[A_W-2];
    assign done     = done_r;
    assign busy_cnt = busy_cnt_r;

endmodule

// File: tb/tb_asm_dp.sv
// Directed self-checking bench for asm_dp (default widths A_W=4, CNT_W=8).
module tb_asm_dp;

    logic       clk;
    logic       rst;
    logic [7:0] dec_in;
    logic [3:0] data_in;
    logic [3:0] A;
    logic       E;
    logic       F;
    logic       done;
    logic [7:0] busy_cnt;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;
    logic exp_err;

    asm_dp dut (
        .clk      (clk),
        .rst      (rst),
        .dec_in   (dec_in),
        .data_in  (data_in),
        .A        (A),
        .E        (E),
        .F        (F),
        .done     (done),
        .busy_cnt (busy_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply inputs, then sample 1 time unit after the next rising edge.
    task automatic cyc(input logic [7:0] d, input logic [3:0] di);
        dec_in  = d;
        data_in = di;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef ASM_DP_ONEHOT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst     = 1'b1;
        dec_in  = 8'h80;
        data_in = 4'h0;
        #12;
        chk("rst_A", 32'(A), 32'h0);
        chk("rst_E", 32'(E), 32'h0);
        chk("rst_F", 32'(F), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Load and flags
        cyc(8'h80, 4'hB);
        chk("load_A", 32'(A), 32'hB);
        chk("load_F", 32'(F), 32'h1);
        chk("load_E", 32'(E), 32'h0);
        chk("load_busy", 32'(busy_cnt), 32'h0);

        // Increment, then wrap
        cyc(8'h80, 4'h3);
        cyc(8'h40, 4'h0);
        chk("inc_A", 32'(A), 32'h4);
        chk("inc_E", 32'(E), 32'h1);
        chk("inc_busy", 32'(busy_cnt), 32'h1);
        cyc(8'h80, 4'hF);
        cyc(8'h40, 4'h0);
        chk("wrap_A", 32'(A), 32'h0);
        chk("wrap_E", 32'(E), 32'h0);
        chk("wrap_F", 32'(F), 32'h0);

        // Decrement with borrow wrap
        cyc(8'h04, 4'h0);
        chk("dec_wrap_A", 32'(A), 32'hF);

        // Decrement, shift, complement
        cyc(8'h80, 4'h9);
        cyc(8'h04, 4'h0);
        chk("dec_A", 32'(A), 32'h8);
        cyc(8'h80, 4'h6);
        cyc(8'h02, 4'h0);
        chk("shl_A", 32'(A), 32'hC);
        cyc(8'h80, 4'h5);
        cyc(8'h01, 4'h0);
        chk("cpl_A", 32'(A), 32'hA);

        // Hold states S010 and S100
        cyc(8'h20, 4'h1);
        chk("hold010_A", 32'(A), 32'hA);
        cyc(8'h08, 4'h1);
        chk("hold100_A", 32'(A), 32'hA);

        // Clear and done pulse
        cyc(8'h80, 4'h7);
        chk("pre_clr_done", 32'(done), 32'h0);
        cyc(8'h10, 4'h0);
        chk("clr_A", 32'(A), 32'h0);
        chk("clr_done", 32'(done), 32'h1);
        cyc(8'h20, 4'h0);
        chk("done_drop", 32'(done), 32'h0);
        cyc(8'h10, 4'h0);
        cyc(8'h10, 4'h0);
        chk("done_b2b", 32'(done), 32'h1);
        cyc(8'h40, 4'h0);
        chk("done_b2b_end", 32'(done), 32'h0);

        // Asynchronous reset mid-run with A=9, busy_cnt=5
        cyc(8'h80, 4'h9);
        for (int i = 0; i < 5; i++) cyc(8'h20, 4'h0);
        chk("pre_rst_A", 32'(A), 32'h9);
        chk("pre_rst_busy", 32'(busy_cnt), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_A", 32'(A), 32'h0);
        chk("arst_F", 32'(F), 32'h0);
        chk("arst_busy", 32'(busy_cnt), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Busy counter saturation over 300 non-S000 cycles
        cyc(8'h80, 4'h0);
        for (int i = 0; i < 254; i++) cyc(8'h20, 4'h0);
        chk("busy_254", 32'(busy_cnt), 32'd254);
        for (int i = 0; i < 46; i++) cyc(8'h20, 4'h0);
        chk("busy_sat", 32'(busy_cnt), 32'd255);
        cyc(8'h80, 4'h0);
        chk("busy_clear", 32'(busy_cnt), 32'h0);

        // Illegal decode
        cyc(8'h80, 4'h3);
        chk("pre_ill_err", 32'(err), 32'h0);
        cyc(8'h41, 4'hE);
        chk("ill_A", 32'(A), 32'h3);
        chk("ill_busy", 32'(busy_cnt), 32'h0);
        chk("ill_err", 32'(err), 32'(exp_err));
        cyc(8'h40, 4'hE);
        chk("post_ill_A", 32'(A), 32'h4);
        chk("post_ill_err", 32'(err), 32'(exp_err));
        cyc(8'h10, 4'h0);
        cyc(8'h00, 4'hE);
        chk("zero_dec_A", 32'(A), 32'h0);
        chk("zero_dec_done", 32'(done), 32'h0);
        chk("zero_dec_busy", 32'(busy_cnt), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
